// File: rtl/pipe_pkg.sv
// Shared types and helpers for the generic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_occ_t;

    // Largest value a w-bit saturating counter can hold (w limited to 1..32).
    function automatic int unsigned sat_max(input int unsigned w);
        if (w >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
interface pipe_stage_if #(
    parameter int WIDTH = 32
);
    // A beat transfers on a side when valid & ready are both high at the rising
    // edge; a valid beat holds its data stable until it transfers.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport stage (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data
    );

    modport tb (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter that adds 0..3 per cycle and never wraps.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       inc_amt,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W+1:0] MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W+1:0] sum;

    assign sum = {2'b00, value} + {{CNT_W{1'b0}}, inc_amt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (sum > MAX) begin
            value <= MAX[CNT_W-1:0];
        end else begin
            value <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, synchronous
// flush to a bubble value and saturating stall/idle/drop counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter bit               SKID        = 1'b1,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_if.stage      bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] idle_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output pipe_occ_t        state_dbg
);

    pipe_occ_t        state_q, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    generate
        if (SKID) begin : g_skid
            // Registered ready: low exactly while both entries are occupied.
            logic rdy_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rdy_q <= 1'b1;
                else     rdy_q <= (state_n != TWO);
            end
            assign in_ready = rdy_q;
        end else begin : g_comb
            assign in_ready = !out_valid | bus.out_ready;
        end
    endgenerate

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (bus.flush) begin
            state_n = EMPTY;
            main_n  = FLUSH_VALUE;
            skid_n  = FLUSH_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_n  = bus.in_data;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_n  = bus.in_data;
                        state_n = TWO;
                    end else if (in_fire && out_fire) begin
                        main_n  = bus.in_data;
                    end else if (out_fire) begin
                        main_n  = FLUSH_VALUE;
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_n  = skid_q;
                        skid_n  = FLUSH_VALUE;
                        state_n = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_VALUE;
            skid_q  <= FLUSH_VALUE;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;
    assign state_dbg     = state_q;

    // Entries killed by a flush: whatever stays behind plus any beat accepted now.
    logic [1:0] drop_amt;
    logic [1:0] stall_inc;
    logic [1:0] idle_inc;
    logic [1:0] drop_inc;

    assign drop_amt  = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
    assign stall_inc = {1'b0, out_valid & !bus.out_ready};
    assign idle_inc  = {1'b0, !out_valid & bus.out_ready};
    assign drop_inc  = bus.flush ? drop_amt : 2'd0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .clear(1'b0), .inc_amt(stall_inc), .value(stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_idle_cnt (
        .clk(clk), .rst(rst), .clear(1'b0), .inc_amt(idle_inc), .value(idle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk(clk), .rst(rst), .clear(1'b0), .inc_amt(drop_inc), .value(drop_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid variant A (plus a 4-bit-counter twin C) and
// a combinational-ready variant B, checked by vector tables and scoreboards.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] FV = 8'hEE;

  int checks = 0;
  int failures = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // stimulus shared by A and C; separate stimulus for B
  logic a_iv = 0, a_or = 0, a_fl = 0;
  logic [W-1:0] a_id = '0;
  logic b_iv = 0, b_or = 0, b_fl = 0;
  logic [W-1:0] b_id = '0;

  pipe_stage_if #(.WIDTH(W)) if_a ();
  pipe_stage_if #(.WIDTH(W)) if_b ();
  pipe_stage_if #(.WIDTH(W)) if_c ();

  assign if_a.in_valid = a_iv;  assign if_a.in_data = a_id;
  assign if_a.out_ready = a_or; assign if_a.flush = a_fl;
  assign if_c.in_valid = a_iv;  assign if_c.in_data = a_id;
  assign if_c.out_ready = a_or; assign if_c.flush = a_fl;
  assign if_b.in_valid = b_iv;  assign if_b.in_data = b_id;
  assign if_b.out_ready = b_or; assign if_b.flush = b_fl;

  logic [1:0] a_occ, b_occ, c_occ;
  logic [15:0] a_stall, a_idle, a_drop, b_stall, b_idle, b_drop;
  logic [3:0] c_stall, c_idle, c_drop;
  pipe_occ_t a_st, b_st, c_st;

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .FLUSH_VALUE(FV), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .occupancy(a_occ), .stall_cnt(a_stall),
    .idle_cnt(a_idle), .drop_cnt(a_drop), .state_dbg(a_st));

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .FLUSH_VALUE(FV), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .occupancy(b_occ), .stall_cnt(b_stall),
    .idle_cnt(b_idle), .drop_cnt(b_drop), .state_dbg(b_st));

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .FLUSH_VALUE(FV), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c), .occupancy(c_occ), .stall_cnt(c_stall),
    .idle_cnt(c_idle), .drop_cnt(c_drop), .state_dbg(c_st));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard for A (C shares its stimulus, checked on occupancy and stall)
  logic [W-1:0] exp_q[$];
  int unsigned stall_e = 0, idle_e = 0, drop_e = 0, stall_ce = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_e = 0; idle_e = 0; drop_e = 0; stall_ce = 0;
    end else begin
      automatic int sz = exp_q.size();
      automatic logic ov_m = (sz != 0);
      automatic logic ir_m = (sz < 2);
      automatic logic in_f = a_iv & ir_m;
      automatic logic out_f = ov_m & a_or;
      chk("a_occ", a_occ, sz);
      chk("a_state", a_st, sz);
      chk("a_out_valid", if_a.out_valid, ov_m);
      chk("a_out_data", if_a.out_data, ov_m ? exp_q[0] : FV);
      chk("a_in_ready", if_a.in_ready, ir_m);
      chk("a_stall", a_stall, stall_e);
      chk("a_idle", a_idle, idle_e);
      chk("a_drop", a_drop, drop_e);
      chk("c_occ", c_occ, sz);
      chk("c_stall", c_stall, stall_ce);
      if (ov_m && !a_or) begin
        stall_e++;
        if (stall_ce < sat_max(4)) stall_ce++;
      end
      if (!ov_m && a_or) idle_e++;
      if (out_f) void'(exp_q.pop_front());
      if (a_fl) begin
        drop_e += exp_q.size() + (in_f ? 1 : 0);
        exp_q.delete();
      end else if (in_f) begin
        exp_q.push_back(a_id);
      end
    end
  end

  // scoreboard for B
  logic [W-1:0] exp_b_q[$];
  int unsigned stall_be = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_b_q.delete();
      stall_be = 0;
    end else begin
      automatic int sz = exp_b_q.size();
      automatic logic ov_m = (sz != 0);
      automatic logic ir_m = !ov_m | b_or;
      automatic logic in_f = b_iv & ir_m;
      automatic logic out_f = ov_m & b_or;
      chk("b_occ", b_occ, sz);
      chk("b_out_valid", if_b.out_valid, ov_m);
      chk("b_out_data", if_b.out_data, ov_m ? exp_b_q[0] : FV);
      chk("b_in_ready", if_b.in_ready, ir_m);
      chk("b_stall", b_stall, stall_be);
      if (ov_m && !b_or) stall_be++;
      if (out_f) void'(exp_b_q.pop_front());
      if (b_fl) exp_b_q.delete();
      else if (in_f) exp_b_q.push_back(b_id);
    end
  end

  // vector table: inputs for one cycle and A's expected outputs in that cycle
  typedef struct {
    logic iv; logic [W-1:0] id; logic ordy; logic fl;
    logic ov; logic [W-1:0] od; logic [1:0] occ; logic ir;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(logic iv, logic [W-1:0] id, logic ordy, logic fl,
                              logic ov, logic [W-1:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  initial begin
    // streaming 0x1..0x8 (rows 0..9)
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(1, W'(k + 1), 1, 0, k > 0, (k > 0) ? W'(k) : FV, (k > 0) ? 2'd1 : 2'd0, 1);
    vecs[8]  = mk(0, 8'h00, 1, 0, 1, 8'h08, 1, 1);
    vecs[9]  = mk(0, 8'h00, 1, 0, 0, FV,    0, 1);
    // backpressure 0xA, 0xB, 0xC (rows 10..17)
    vecs[10] = mk(1, 8'h0A, 0, 0, 0, FV,    0, 1);
    vecs[11] = mk(1, 8'h0B, 0, 0, 1, 8'h0A, 1, 1);
    vecs[12] = mk(1, 8'h0C, 0, 0, 1, 8'h0A, 2, 0);
    vecs[13] = mk(1, 8'h0C, 0, 0, 1, 8'h0A, 2, 0);
    vecs[14] = mk(1, 8'h0C, 1, 0, 1, 8'h0A, 2, 0);
    vecs[15] = mk(1, 8'h0C, 1, 0, 1, 8'h0B, 1, 1);
    vecs[16] = mk(0, 8'h00, 1, 0, 1, 8'h0C, 1, 1);
    vecs[17] = mk(0, 8'h00, 0, 0, 0, FV,    0, 1);
    // flush with two held and a concurrent out_fire (rows 18..21)
    vecs[18] = mk(1, 8'h0A, 0, 0, 0, FV,    0, 1);
    vecs[19] = mk(1, 8'h0B, 0, 0, 1, 8'h0A, 1, 1);
    vecs[20] = mk(1, 8'h0C, 1, 1, 1, 8'h0A, 2, 0);
    vecs[21] = mk(0, 8'h00, 0, 0, 0, FV,    0, 1);
    // flush with one held plus an accepted incoming beat (rows 22..24)
    vecs[22] = mk(1, 8'h0D, 0, 0, 0, FV,    0, 1);
    vecs[23] = mk(1, 8'h0E, 0, 1, 1, 8'h0D, 1, 1);
    vecs[24] = mk(0, 8'h00, 0, 0, 0, FV,    0, 1);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      a_iv = vecs[i].iv; a_id = vecs[i].id; a_or = vecs[i].ordy; a_fl = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), if_a.out_valid, vecs[i].ov);
      chk($sformatf("vec%0d_out_data", i), if_a.out_data, vecs[i].od);
      chk($sformatf("vec%0d_occ", i), a_occ, vecs[i].occ);
      chk($sformatf("vec%0d_in_ready", i), if_a.in_ready, vecs[i].ir);
      if (i == 8)  chk("idle_after_stream", a_idle, 1);
      if (i == 17) chk("stall_after_backpressure", a_stall, 3);
      if (i == 21) chk("drop_after_flush2", a_drop, 1);
      if (i == 24) chk("drop_after_flush_in", a_drop, 3);
    end

    // SKID=0: combinational ready and simultaneous in/out transfer
    @(posedge clk);
    #1 b_iv = 1; b_id = 8'h11; b_or = 0;
    @(negedge clk);
    chk("b_ir_empty", if_b.in_ready, 1);
    @(posedge clk);
    #1 b_id = 8'h22;
    #1 chk("b_ir_comb_low", if_b.in_ready, 0);
    chk("b_occ_held", b_occ, 1);
    b_or = 1;
    #1 chk("b_ir_comb_high", if_b.in_ready, 1);
    @(posedge clk);
    #1 chk("b_simul_occ", b_occ, 1);
    chk("b_simul_data", if_b.out_data, 8'h22);
    for (int k = 0; k < 4; k++) begin
      b_id = W'(8'h31 + k);
      @(posedge clk);
      #1;
    end
    b_iv = 0;
    repeat (3) @(posedge clk);
    #1 b_or = 0;

    // saturation on the 4-bit counters of C
    a_iv = 1; a_id = 8'h77; a_or = 0;
    @(posedge clk);
    #1 a_iv = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("c_stall_sat", c_stall, 15);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("c_stall_hold", c_stall, 15);
    @(posedge clk);
    #1 a_or = 1;
    @(posedge clk);
    #1 a_or = 0;

    // asynchronous reset with two entries held
    a_iv = 1; a_id = 8'h55;
    @(posedge clk);
    #1 a_id = 8'h66;
    @(posedge clk);
    #1 a_iv = 0;
    #1 chk("pre_rst_occ", a_occ, 2);
    #2 rst = 1;
    #1;
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_out_data", if_a.out_data, FV);
    chk("rst_in_ready", if_a.in_ready, 1);
    chk("rst_stall", a_stall, 0);
    chk("rst_idle", a_idle, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_c_stall", c_stall, 0);
    chk("rst_b_in_ready", if_b.in_ready, 1);
    chk("rst_b_stall", b_stall, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_drop", a_drop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
